// File: rtl/fft_reorder_ctrl.sv
// Single-symbol reorder buffer: FFT words are written into the symbol RAM at bit-reversed
// addresses, then read back in natural order to the downstream stream. The two phases never overlap.
module fft_reorder_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int RAM_DEPTH  = 32,
    parameter bit BIT_REV    = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iIn_Valid,
    input  logic [DATA_WIDTH-1:0] iIn_Data,
    output logic                  oIn_Ready,
    output logic                  oOut_Valid,
    output logic [DATA_WIDTH-1:0] oOut_Data,
    input  logic                  iOut_Ready,
    output logic                  oRam_REN,
    output logic                  oRam_WEN,
    output logic [ADDR_WIDTH-1:0] oRam_Addr,
    output logic [DATA_WIDTH-1:0] oRam_WData,
    input  logic [DATA_WIDTH-1:0] iRam_RData,
    output logic                  oBusy,
    output logic                  oSym_Done
);
    typedef enum logic {S_WRITE = 1'b0, S_READ = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] W_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   R_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   R_END  = (ADDR_WIDTH+1)'(RAM_DEPTH);

    function automatic logic [ADDR_WIDTH-1:0] f_bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
        return r;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wcnt, w_wcnt_nxt;
    // One extra bit so the read counter can sit at RAM_DEPTH once every read is issued.
    logic [ADDR_WIDTH:0]   r_rcnt, w_rcnt_nxt;
    logic                  r_out_vld, w_out_vld_nxt;
    logic                  r_sym_done, w_sym_done_nxt;
    logic                  w_wr, w_rd, w_out_hs;
    logic [ADDR_WIDTH-1:0] w_addr;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_WRITE;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_out_vld  <= 1'b0;
            r_sym_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_out_vld  <= w_out_vld_nxt;
            r_sym_done <= w_sym_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_rcnt_nxt     = r_rcnt;
        w_out_vld_nxt  = r_out_vld;
        w_sym_done_nxt = 1'b0;
        w_wr           = 1'b0;
        w_rd           = 1'b0;
        w_out_hs       = 1'b0;
        w_addr         = '0;
        case (r_state)
            S_WRITE: begin
                w_wr = iIn_Valid;
                if (w_wr) begin
                    w_addr = BIT_REV ? f_bitrev(r_wcnt) : r_wcnt;
                    if (r_wcnt == W_LAST) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = S_READ;
                    end else begin
                        w_wcnt_nxt = r_wcnt + W_ONE;
                    end
                end
            end
            S_READ: begin
                w_out_hs = r_out_vld & iOut_Ready;
                // Issue only into a free slot so the RAM output register doubles as the holding stage.
                w_rd = (r_rcnt != R_END) && (!r_out_vld || iOut_Ready);
                if (w_rd) begin
                    w_addr     = r_rcnt[ADDR_WIDTH-1:0];
                    w_rcnt_nxt = r_rcnt + R_ONE;
                end
                if (w_rd)
                    w_out_vld_nxt = 1'b1;
                else if (w_out_hs)
                    w_out_vld_nxt = 1'b0;
                if (w_out_hs && (r_rcnt == R_END)) begin
                    w_rcnt_nxt     = '0;
                    w_state_nxt    = S_WRITE;
                    w_sym_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_WRITE;
        endcase
    end

    // Write strobe and address are combinational from iIn_Valid, so mask them while reset is held.
    assign oIn_Ready  = (r_state == S_WRITE);
    assign oBusy      = (r_state == S_READ);
    assign oRam_WEN   = w_wr & ~iRst;
    assign oRam_REN   = w_rd & ~iRst;
    assign oRam_Addr  = iRst ? '0 : w_addr;
    assign oRam_WData = iIn_Data;
    assign oOut_Valid = r_out_vld;
    assign oOut_Data  = iRam_RData;
    assign oSym_Done  = r_sym_done;

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Bench for fft_reorder_ctrl: two instances (bit-reversed and linear) on shared stimulus,
// each with a behavioural single-port RAM, checked against a queue-based symbol model.
module tb_fft_reorder_ctrl;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk, rst, in_vld, out_rdy;
    logic [DW-1:0] in_dat;
    logic          a_in_rdy, a_ovld, a_ren, a_wen, a_busy, a_done;
    logic [DW-1:0] a_odat, a_wdat, a_rdat;
    logic [AW-1:0] a_addr;
    logic          b_in_rdy, b_ovld, b_ren, b_wen, b_busy, b_done;
    logic [DW-1:0] b_odat, b_wdat, b_rdat;
    logic [AW-1:0] b_addr;

    fft_reorder_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(N), .BIT_REV(1'b1)) dut (
        .iClk(clk), .iRst(rst), .iIn_Valid(in_vld), .iIn_Data(in_dat), .oIn_Ready(a_in_rdy),
        .oOut_Valid(a_ovld), .oOut_Data(a_odat), .iOut_Ready(out_rdy),
        .oRam_REN(a_ren), .oRam_WEN(a_wen), .oRam_Addr(a_addr), .oRam_WData(a_wdat),
        .iRam_RData(a_rdat), .oBusy(a_busy), .oSym_Done(a_done));

    fft_reorder_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(N), .BIT_REV(1'b0)) dut_lin (
        .iClk(clk), .iRst(rst), .iIn_Valid(in_vld), .iIn_Data(in_dat), .oIn_Ready(b_in_rdy),
        .oOut_Valid(b_ovld), .oOut_Data(b_odat), .iOut_Ready(out_rdy),
        .oRam_REN(b_ren), .oRam_WEN(b_wen), .oRam_Addr(b_addr), .oRam_WData(b_wdat),
        .iRam_RData(b_rdat), .oBusy(b_busy), .oSym_Done(b_done));

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    always @(posedge clk) begin
        if (a_wen) mem_a[a_addr] <= a_wdat;
        if (a_ren) a_rdat <= mem_a[a_addr];
        if (b_wen) mem_b[b_addr] <= b_wdat;
        if (b_ren) b_rdat <= mem_b[b_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int brev(input int j);
        int r = 0;
        for (int i = 0; i < AW; i++) r = r * 2 + (j / (2 ** i)) % 2;
        return r;
    endfunction

    // Symbol model: accepted words collect in wq; a full symbol becomes the expected output order.
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_l[$];
    bit            m_in_write, first_seen, prev_held, prev_done, chk_tim, bp_en;
    logic [DW-1:0] held_dat;
    int            t_last, t_done, t_first_wr, n_out, n_done;

    initial begin
        first_seen = 0; prev_held = 0; prev_done = 0; chk_tim = 0; bp_en = 0;
        t_last = 0; t_done = 0; t_first_wr = 0; n_out = 0; n_done = 0; held_dat = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            wq.delete(); exp_q.delete(); exp_l.delete();
            prev_held = 0; prev_done = 0; first_seen = 0;
        end else begin
            m_in_write = (exp_q.size() == 0);
            chk("in_rdy", a_in_rdy, m_in_write);
            chk("busy", a_busy, !m_in_write);
            chk("excl", a_ren & a_wen, 0);
            chk("excl_lin", b_ren & b_wen, 0);
            if (in_vld && m_in_write) begin
                chk("wen", a_wen, 1);
                chk("waddr", a_addr, brev(wq.size()));
                chk("waddr_lin", b_addr, wq.size());
                chk("wdat", a_wdat, in_dat);
                if (wq.size() == 0) t_first_wr = cyc;
                wq.push_back(in_dat);
                if (wq.size() == N) begin
                    for (int j = 0; j < N; j++) begin
                        exp_q.push_back(wq[brev(j)]);
                        exp_l.push_back(wq[j]);
                    end
                    wq.delete();
                    t_last = cyc;
                    first_seen = 0;
                end
            end else if (m_in_write) begin
                chk("idle_wen", a_wen, 0);
                chk("idle_ren", a_ren, 0);
                chk("idle_addr", a_addr, 0);
            end else begin
                chk("rd_lock_wen", a_wen, 0);
            end
            if (a_ovld && !first_seen) begin
                first_seen = 1;
                if (chk_tim) chk("first_vld_cyc", cyc, t_last + 2);
            end
            if (prev_held) begin
                chk("hold_vld", a_ovld, 1);
                chk("hold_dat", a_odat, held_dat);
            end
            if (a_ovld && !out_rdy) chk("held_ren", a_ren, 0);
            prev_held = a_ovld && !out_rdy;
            held_dat = a_odat;
            if (a_ovld && out_rdy) begin
                if (exp_q.size() == 0) chk("extra_out", 1, 0);
                else chk("out_dat", a_odat, exp_q.pop_front());
                n_out++;
            end
            if (b_ovld && out_rdy) begin
                if (exp_l.size() == 0) chk("extra_out_lin", 1, 0);
                else chk("out_dat_lin", b_odat, exp_l.pop_front());
            end
            if (a_done) begin
                n_done++;
                t_done = cyc;
                chk("done_rdy", a_in_rdy, 1);
                chk("done_once", prev_done, 0);
                chk("done_q_empty", exp_q.size(), 0);
                if (chk_tim) chk("done_cyc", cyc, t_last + N + 2);
            end
            prev_done = a_done;
        end
    end

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_rdy = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Presents n words; leaves in_vld as-is on return so the next symbol can follow back-to-back.
    task automatic send_symbol(input int n, input logic [DW-1:0] base, input bit rnd, input bit gaps);
        int k = 0;
        int c = 0;
        while (k < n && c < 600) begin
            in_vld = !(gaps && (c % 3 == 2));
            in_dat = rnd ? {$urandom, $urandom} : base + DW'(k);
            @(negedge clk);
            if (in_vld && a_in_rdy) k++;
            @(posedge clk); #1;
            c++;
        end
        chk("send_timeout", k, n);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        chk("done_timeout", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_rdy"}, a_in_rdy, 1);
        chk({tag, "_ovld"}, a_ovld, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_ren"}, a_ren, 0);
        chk({tag, "_wen"}, a_wen, 0);
        chk({tag, "_addr"}, a_addr, 0);
    endtask

    int n_sym_exp = 0;
    int n0;

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // bit-reversed order with timing, data k = 0..31
        chk_tim = 1;
        send_symbol(N, 64'd0, 0, 0);
        in_vld = 0;
        wait_done(); n_sym_exp++;
        chk_tim = 0;

        // random data under random output backpressure
        bp_en = 1;
        for (int s = 0; s < 3; s++) begin
            send_symbol(N, 64'd0, 1, 0);
            in_vld = 0;
            wait_done(); n_sym_exp++;
        end
        bp_en = 0;

        // input gaps every third cycle
        send_symbol(N, 64'd200, 0, 1);
        in_vld = 0;
        wait_done(); n_sym_exp++;

        // reset after 10 writes, with in_vld still high
        send_symbol(10, 64'd300, 0, 0);
        #2; rst = 1'b1; #1;
        chk_reset("rst_wr");
        in_vld = 0;
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // reset during READ after 5 outputs
        send_symbol(N, 64'd400, 0, 0);
        in_vld = 0;
        n0 = n_out;
        for (int c = 0; c < 200 && n_out < n0 + 5; c++) @(negedge clk);
        chk("rd_out5", n_out - n0, 5);
        @(posedge clk); #2;
        chk("busy_before_rst", a_busy, 1);
        rst = 1'b1; #1;
        chk_reset("rst_rd");
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // full symbol 100+k after the aborted ones
        chk_tim = 1;
        send_symbol(N, 64'd100, 0, 0);
        in_vld = 0;
        wait_done(); n_sym_exp++;
        chk_tim = 0;

        // in_vld held through READ; next symbol must start in the done cycle
        send_symbol(N, 64'd500, 0, 0);
        send_symbol(N, 64'd600, 0, 0);
        n_sym_exp++;
        chk("accept_at_done", t_first_wr, t_done);
        in_vld = 0;
        wait_done(); n_sym_exp++;

        repeat (3) @(posedge clk);
        #1;
        chk("sym_done_count", n_done, n_sym_exp);
        chk("final_idle_q", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
